// File: rtl/mem_arbiter.sv
// Round-robin arbiter that shares one single-port, word-addressed memory between
// an instruction-fetch port (0, read-only) and a load/store port (1).
module mem_arbiter #(
    parameter int LAT = 1,
    parameter int AW  = 30
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic [31:0]   a0,
    input  logic          req1,
    input  logic [31:0]   a1,
    input  logic          we1,
    input  logic [31:0]   wd1,
    output logic          ack0,
    output logic          ack1,
    output logic [31:0]   rdata,
    output logic          busy,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_a,
    output logic [31:0]   mem_wd,
    input  logic [31:0]   mem_rd
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        DONE
    } state_t;

    localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

    state_t     state;
    state_t     state_next;
    logic       port_q;
    logic       we_q;
    logic       last_grant;
    logic [3:0] cnt;
    logic       grant_valid;
    logic       grant_port;
    logic       sample;

    // Byte-offset bits and any bits above the word address are deliberately dropped.
    logic unused_addr;
    assign unused_addr = ^{a0, a1};

    // On contention the port that did not win last time gets the grant.
    always_comb begin
        grant_valid = req0 | req1;
        grant_port  = 1'b0;
        if (req0 && req1) begin
            grant_port = ~last_grant;
        end else if (req1) begin
            grant_port = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of process ordering.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_next = state;
        sample     = 1'b0;
        ack0       = 1'b0;
        ack1       = 1'b0;
        mem_en     = 1'b0;
        mem_we     = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (grant_valid) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                // Strobes are gated by reset so an aborted access disappears at once.
                mem_en = ~reset;
                mem_we = we_q & ~reset;
                if (LAT == 1) begin
                    sample     = 1'b1;
                    state_next = DONE;
                end else begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (cnt == 4'd1) begin
                    sample     = 1'b1;
                    state_next = DONE;
                end
            end
            DONE: begin
                ack0       = ~port_q;
                ack1       = port_q;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            port_q     <= 1'b0;
            we_q       <= 1'b0;
            last_grant <= 1'b1;
            mem_a      <= '0;
            mem_wd     <= '0;
            cnt        <= '0;
            rdata      <= '0;
        end else begin
            if (state == IDLE && grant_valid) begin
                port_q     <= grant_port;
                last_grant <= grant_port;
                we_q       <= grant_port & we1;
                mem_a      <= grant_port ? a1[AW+1:2] : a0[AW+1:2];
                if (grant_port) begin
                    mem_wd <= wd1;
                end
            end

            if (state == ISSUE) begin
                cnt <= CNT_INIT;
            end else if (state == WAIT) begin
                cnt <= cnt - 4'd1;
            end

            // Stores never disturb the last load result.
            if (sample && !we_q) begin
                rdata <= mem_rd;
            end
        end
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-port word-addressed memory between two requesters: port 0 (instruction fetch, read-only) and port 1 (load/store, read/write). Each request goes through an issue/wait/acknowledge sequence. Conflicts are resolved round-robin. The block sits between the processor core and a unified memory with a configurable read latency, which allows a Von Neumann memory map to replace separate imem/dmem arrays.

Parameters:
LAT, 1, memory read latency in cycles, legal range 1..15 (1 = asynchronous-read array: data valid in the same cycle as mem_en)
AW, 30, width of the word address driven to memory

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
req0  input  1  port 0 request; held high with a0 stable until ack0
a0  input  32  port 0 byte address; bits [1:0] ignored
req1  input  1  port 1 request; held high with a1/we1/wd1 stable until ack1
a1  input  32  port 1 byte address; bits [1:0] ignored
we1  input  1  port 1 write enable (1 = store, 0 = load)
wd1  input  32  port 1 write data
ack0  output  1  one-cycle pulse: port 0 transfer complete, rdata valid
ack1  output  1  one-cycle pulse: port 1 transfer complete (rdata valid if load)
rdata  output  32  read data, shared, registered
busy  output  1  high in every state other than IDLE
mem_en  output  1  memory access strobe
mem_we  output  1  memory write strobe, only ever high while mem_en is high
mem_a  output  AW  word address = latched a[AW+1:2]
mem_wd  output  32  latched write data
mem_rd  input  32  memory read data

Behaviour:
- Reset (asynchronous, immediate): state=IDLE; ack0=ack1=0; rdata=0; mem_en=mem_we=0; mem_a=0; mem_wd=0; busy=0; last_grant=1.
- FSM states: IDLE, ISSUE, WAIT, DONE.
- IDLE:
  - No req: stay in IDLE.
  - Exactly one req: grant that port.
  - Both req: grant the port that is not last_grant.
  - On grant: latch port id, address, we (port 0 forces we=0) and wd; update last_grant; go to ISSUE.
- ISSUE (one cycle):
  - mem_en=1; mem_we=latched we; mem_a/mem_wd driven from the latches.
  - cnt loads LAT-1.
  - If LAT=1: sample mem_rd into rdata at the end of this cycle (loads only) and go to DONE.
  - Otherwise go to WAIT.
- WAIT:
  - mem_en=0; cnt decrements each cycle.
  - When cnt=1, sample mem_rd into rdata (loads only) and go to DONE.
  - Total sample point is the end of cycle ISSUE+LAT-1.
- DONE (one cycle): ack of the granted port=1; go to IDLE. req inputs are ignored in DONE.
- Stores leave rdata unchanged.
- Latency: the req first seen in IDLE at cycle t gives ack at cycle t+LAT+1. Back-to-back requests from one port are at best LAT+2 cycles apart.
- Requester rules:
  - Must keep req and its operands stable until it samples ack.
  - req still high in the cycle after ack is treated as a new request.
  - req dropped before ack is a protocol violation; behaviour is undefined but the FSM still completes the latched access.
- A losing requester waits in IDLE with no starvation: under continuous contention grants strictly alternate 0,1,0,1…
- mem_a and mem_wd hold their last latched value while idle. Only mem_en and mem_we have strobe meaning.
- Reset mid-operation:
  - mem_en and mem_we drop combinationally with reset.
  - No ack is issued for the aborted access.
  - A store aborted during ISSUE may or may not have committed.
- Out-of-range address bits above AW+1 are ignored (wrap-around).

Test Plan:
- LAT=1, req0 only, a0=0x0000_0008, mem_rd=0xDEAD_BEEF during ISSUE -> mem_en high one cycle with mem_a=2, mem_we=0; ack0 pulse 2 cycles after req seen; rdata=0xDEAD_BEEF; ack1 stays 0.
- LAT=1, port 1 store a1=0x10, wd1=0x1234_5678, then load a1=0x10 against a behavioural memory -> store: mem_we=1 with mem_a=4, ack1 pulse, rdata unchanged; load: rdata=0x1234_5678.
- req0 and req1 raised together and held continuously -> first grant to port 0 (last_grant reset=1), then grants alternate 0,1,0,1; each ack spaced LAT+2 cycles apart; no port gets two grants in a row.
- LAT=3, port 0 load, memory returns data 2 cycles after mem_en -> ISSUE plus 2 WAIT cycles; rdata sampled at end of cycle ISSUE+2; ack0 at t+4; busy high from t+1 through t+4.
- LAT=3, reset asserted during WAIT -> busy, mem_en and the acks go to 0 immediately; rdata=0; after reset release, a pending req1 is granted cleanly with correct timing.
- Single port holds req1 high across ack1 -> new access starts in the next IDLE cycle; ack1 pulses repeat every LAT+2 cycles; ack1 is never high two cycles in a row.
